// File: rtl/cdma_job_arbiter.sv
// cdma_job_arbiter: round-robin job scheduler in front of one AXI CDMA.
// Optional: CDMA_ARB_RESP_CHECK_EN turns non-OKAY bresp/rresp into job errors.
module cdma_job_arbiter #(
  parameter int         NREQ        = 2,
  parameter logic [9:0] STATUS_ADDR = 10'h04
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_src,
  input  logic [32*NREQ-1:0]   req_dst,
  input  logic [32*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [9:0]           awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [9:0]           araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, RADDR, RDATA, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     len_q, len_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            fail_q, fail_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic [9:0]      awaddr_q, awaddr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [31:0]     psrc, pdst, plen;

  // Status bits other than Idle/errors and, without the check, the responses.
  logic unused_in;
  assign unused_in = ^{bresp, rresp, rdata[31:7], rdata[3:2], rdata[0]};

  // First requesting slot at or after rr_ptr, wrapping around.
  always_comb begin : arb
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    psrc  = '0;
    pdst  = '0;
    plen  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
        psrc  = req_src[32*j +: 32];
        pdst  = req_dst[32*j +: 32];
        plen  = req_len[32*j +: 32];
      end
    end
  end

  // Next-state, job latch and registered AXI write channel values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    fail_d    = fail_q;
    grant_d   = '0;
    done_d    = '0;
    err_d     = '0;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d        = pick;
          src_d         = psrc;
          dst_d         = pdst;
          len_d         = plen;
          grant_d[pick] = 1'b1;
          idx_d         = 2'd0;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          if (int'(pick) == NREQ - 1) rr_ptr_d = '0;
          else rr_ptr_d = pick + IW'(1);
          if (plen == 32'd0) begin
            fail_d  = 1'b1;
            state_d = FINISH;
          end else begin
            fail_d  = 1'b0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | (awvalid_q & awready);
        w_done_d  = w_done_q | (wvalid_q & wready);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
`ifdef CDMA_ARB_RESP_CHECK_EN
          if (bresp != 2'b00) begin
            fail_d  = 1'b1;
            state_d = FINISH;
          end else
`endif
          if (idx_q < 2'd2) begin
            idx_d     = idx_q + 2'd1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WRITE;
          end else begin
            state_d = RADDR;
          end
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
`ifdef CDMA_ARB_RESP_CHECK_EN
          if (rresp != 2'b00) begin
            fail_d  = 1'b1;
            state_d = FINISH;
          end else
`endif
          if (|rdata[6:4]) begin
            fail_d  = 1'b1;
            state_d = FINISH;
          end else if (rdata[1]) begin
            fail_d  = 1'b0;
            state_d = FINISH;
          end else begin
            state_d = RADDR;
          end
        end
      end
      FINISH: begin
        done_d[gidx_q] = ~fail_q;
        err_d[gidx_q]  = fail_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The grant cycle itself carries no valid; valids start one cycle later.
    awvalid_d = (state_d == WRITE) && (state_q != IDLE) && !aw_done_d;
    wvalid_d  = (state_d == WRITE) && (state_q != IDLE) && !w_done_d;
    if (state_d == WRITE) begin
      unique case (idx_d)
        2'd0: begin
          awaddr_d = 10'h018;
          wdata_d  = src_d;
        end
        2'd1: begin
          awaddr_d = 10'h020;
          wdata_d  = dst_d;
        end
        default: begin
          awaddr_d = 10'h028;
          wdata_d  = len_d;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      fail_q    <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      fail_q    <= fail_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE) | (|done_q) | (|err_q);
  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wvalid  = wvalid_q;
  assign bready  = (state_q == WRESP);
  assign arvalid = (state_q == RADDR);
  assign araddr  = (state_q == RADDR) ? STATUS_ADDR : 10'h000;
  assign rready  = (state_q == RDATA);

endmodule

// File: tb/tb_cdma_job_arbiter.sv
// tb_cdma_job_arbiter: directed bench with a behavioural CDMA slave.
// Build with or without CDMA_ARB_RESP_CHECK_EN.
module tb_cdma_job_arbiter;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [32*NREQ-1:0] req_src = '0;
  logic [32*NREQ-1:0] req_dst = '0;
  logic [32*NREQ-1:0] req_len = '0;
  logic [NREQ-1:0]    grant, done, err;
  logic               busy;
  logic [9:0]         awaddr, araddr;
  logic               awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]        wdata;
  logic               awready = 1'b0, wready = 1'b0;
  logic               bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]         bresp = 2'b00, rresp = 2'b00;
  logic [31:0]        rdata = '0;

  cdma_job_arbiter #(.NREQ(NREQ), .STATUS_ADDR(10'h04)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave knobs (written by the stimulus only).
  int          aw_delay = 0;
  int          b_err_at = -1;
  int          stat_base = 0;
  logic [31:0] stat_arr [3];

  // Slave and monitor state (written by the negedge process only).
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_got = 0, w_got = 0, ar_got = 0;
  int          aw_stall = 0;
  logic [9:0]  aw_log [64];
  logic [31:0] w_log [64];
  int          cyc = 0, grant_cnt = 0, fin_cnt = 0;
  int          grant_cyc = 0, fin_cyc = 0;
  logic [NREQ-1:0] last_grant = '0, last_done = '0, last_err = '0;
  int          grant_log [64];
  int          overlap = 0, stab_err = 0, aw_only = 0;
  logic        job_open = 0, prev_pend = 0;
  logic [9:0]  prev_awaddr = '0;

  // Zero-wait AXI4-Lite slave plus protocol monitor, evaluated mid-cycle.
  always @(negedge clk) begin : slave
    int si;
    int gi;
    cyc++;
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_stall = 0;
      job_open = 0; prev_pend = 0;
    end else begin
      bvalid = aw_got && w_got;
      bresp = (bvalid && b_cnt == b_err_at) ? 2'b10 : 2'b00;
      if (bvalid && bready) begin
        b_cnt++;
        aw_got = 0;
        w_got = 0;
      end
      awready = 0;
      if (awvalid && !aw_got) begin
        if (aw_stall < aw_delay) aw_stall++;
        else begin
          awready = 1;
          aw_stall = 0;
          aw_log[aw_cnt % 64] = awaddr;
          aw_cnt++;
          aw_got = 1;
        end
      end
      wready = 0;
      if (wvalid && !w_got) begin
        wready = 1;
        w_log[w_cnt % 64] = wdata;
        w_cnt++;
        w_got = 1;
      end
      rvalid = ar_got;
      si = r_cnt - stat_base;
      if (si > 2) si = 2;
      if (si < 0) si = 0;
      rdata = rvalid ? stat_arr[si] : 32'h0;
      if (rvalid && rready) begin
        r_cnt++;
        ar_got = 0;
      end
      arready = 0;
      if (arvalid && !ar_got) begin
        if (araddr != 10'h04) stab_err++;
        arready = 1;
        ar_cnt++;
        ar_got = 1;
      end
      if (grant != 0) begin
        if (job_open) overlap++;
        job_open = 1;
        last_grant = grant;
        grant_cyc = cyc;
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
        grant_log[grant_cnt % 64] = gi;
        grant_cnt++;
      end
      if ((done | err) != 0) begin
        job_open = 0;
        last_done = done;
        last_err = err;
        fin_cyc = cyc;
        fin_cnt++;
      end
      if (prev_pend && (!awvalid || awaddr != prev_awaddr)) stab_err++;
      if (awvalid && !wvalid) aw_only++;
      prev_pend = awvalid && !awready;
      prev_awaddr = awaddr;
    end
  end

  typedef struct {
    int          r;
    logic [31:0] src, dst, len;
    logic [31:0] st0, st1, st2;
    logic        ok;
    int          n_aw, n_ar, lat;
  } vec_t;

  vec_t vecs [7];
  int aw_b, w_b, b_b, ar_b, g_b, f_b, ao_b;

  task automatic do_job(input int r, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    int n;
    aw_b = aw_cnt; w_b = w_cnt; b_b = b_cnt; ar_b = ar_cnt;
    stat_base = r_cnt;
    req_src[32*r +: 32] = s;
    req_dst[32*r +: 32] = d;
    req_len[32*r +: 32] = l;
    req[r] = 1'b1;
    n = 0;
    while ((done | err) == 0 && n < 400) begin
      tick();
      n++;
    end
    chk("job_timeout", 64'(n < 400), 64'd1);
    req = '0;
    tick();
  endtask

  initial begin
    logic [9:0] ea [3];
    logic [31:0] ed;
    int n, fins;
    ea[0] = 10'h018; ea[1] = 10'h020; ea[2] = 10'h028;
    vecs[0] = '{0, 32'h1000, 32'h2000, 32'h40, 32'h2, 32'h2, 32'h2, 1'b1, 3, 1, 10};
    vecs[1] = '{1, 32'hA000_0000, 32'hB000_0004, 32'h100, 32'h0, 32'h0, 32'h2, 1'b1, 3, 3, 14};
    vecs[2] = '{0, 32'h3000, 32'h4000, 32'h8, 32'h20, 32'h2, 32'h2, 1'b0, 3, 1, 10};
    vecs[3] = '{1, 32'h5000, 32'h6000, 32'h0, 32'h2, 32'h2, 32'h2, 1'b0, 0, 0, 1};
    vecs[4] = '{0, 32'h7000, 32'h8000, 32'h10, 32'h12, 32'h2, 32'h2, 1'b0, 3, 1, 10};
    vecs[5] = '{1, 32'h9000, 32'h9100, 32'h4, 32'h0, 32'h40, 32'h2, 1'b0, 3, 2, 12};
    vecs[6] = '{0, 32'hC0DE_0000, 32'hBEEF_0000, 32'hFFF, 32'h0, 32'h2, 32'h2, 1'b1, 3, 2, 12};

    repeat (3) tick();
    chk("reset_outs", {grant, done, err, busy, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 7; v++) begin
      stat_arr[0] = vecs[v].st0;
      stat_arr[1] = vecs[v].st1;
      stat_arr[2] = vecs[v].st2;
      do_job(vecs[v].r, vecs[v].src, vecs[v].dst, vecs[v].len);
      chk($sformatf("v%0d_grant", v), 64'(last_grant), 64'(1 << vecs[v].r));
      chk($sformatf("v%0d_done", v), 64'(last_done), vecs[v].ok ? 64'(1 << vecs[v].r) : 64'd0);
      chk($sformatf("v%0d_err", v), 64'(last_err), vecs[v].ok ? 64'd0 : 64'(1 << vecs[v].r));
      chk($sformatf("v%0d_lat", v), 64'(fin_cyc - grant_cyc), 64'(vecs[v].lat));
      chk($sformatf("v%0d_naw", v), 64'(aw_cnt - aw_b), 64'(vecs[v].n_aw));
      chk($sformatf("v%0d_nb", v), 64'(b_cnt - b_b), 64'(vecs[v].n_aw));
      chk($sformatf("v%0d_nar", v), 64'(ar_cnt - ar_b), 64'(vecs[v].n_ar));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
      if (vecs[v].n_aw == 3) begin
        for (int k = 0; k < 3; k++) begin
          ed = (k == 0) ? vecs[v].src : (k == 1) ? vecs[v].dst : vecs[v].len;
          chk($sformatf("v%0d_awaddr%0d", v, k), 64'(aw_log[(aw_b + k) % 64]), 64'(ea[k]));
          chk($sformatf("v%0d_wdata%0d", v, k), 64'(w_log[(w_b + k) % 64]), 64'(ed));
        end
      end
    end

    // AW held off three cycles on every write; W goes first.
    stat_arr[0] = 32'h2; stat_arr[1] = 32'h2; stat_arr[2] = 32'h2;
    aw_delay = 3;
    ao_b = aw_only;
    do_job(0, 32'h1111_0000, 32'h2222_0000, 32'h80);
    aw_delay = 0;
    chk("dly_done", 64'(last_done), 64'd1);
    chk("dly_lat", 64'(fin_cyc - grant_cyc), 64'd19);
    chk("dly_aw_only", 64'(aw_only - ao_b), 64'd9);
    chk("dly_nb", 64'(b_cnt - b_b), 64'd3);
    chk("dly_addr2", 64'(aw_log[(aw_b + 2) % 64]), 64'h028);
    chk("dly_stable", 64'(stab_err), 64'd0);

    // Reset during WRESP of the second write.
    aw_b = aw_cnt;
    req_src[63:32] = 32'h4000; req_dst[63:32] = 32'h5000; req_len[63:32] = 32'h20;
    req[1] = 1'b1;
    n = 0;
    while (!((aw_cnt - aw_b) == 2 && bready) && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reach_wresp", 64'(n < 100), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {grant, done, err, busy, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata}, 64'd0);
    f_b = fin_cnt;
    repeat (3) tick();
    chk("rst_no_fin", 64'(fin_cnt - f_b), 64'd0);

    // After reset both requesters held: grants alternate from slot 0.
    g_b = grant_cnt;
    req_src[31:0] = 32'h100; req_dst[31:0] = 32'h200; req_len[31:0] = 32'h10;
    req = 2'b11;
    rst = 1'b0;
    fins = 0;
    n = 0;
    while (fins < 4 && n < 400) begin
      tick();
      n++;
      if ((done | err) != 0) begin
        fins++;
        if (fins == 4) req = '0;
      end
    end
    chk("alt_timeout", 64'(n < 400), 64'd1);
    tick();
    chk("alt_ngrant", 64'(grant_cnt - g_b), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt_grant%0d", k), 64'(grant_log[(g_b + k) % 64]), 64'(k % 2));
    chk("alt_overlap", 64'(overlap), 64'd0);

    // Error response on the first write.
    b_err_at = b_cnt;
    do_job(0, 32'h6000, 32'h7000, 32'h44);
    b_err_at = -1;
`ifdef CDMA_ARB_RESP_CHECK_EN
    chk("bresp_err", 64'(last_err), 64'd1);
    chk("bresp_naw", 64'(aw_cnt - aw_b), 64'd1);
    chk("bresp_lat", 64'(fin_cyc - grant_cyc), 64'd4);
`else
    chk("bresp_done", 64'(last_done), 64'd1);
    chk("bresp_naw", 64'(aw_cnt - aw_b), 64'd3);
    chk("bresp_lat", 64'(fin_cyc - grant_cyc), 64'd10);
`endif
    chk("final_stable", 64'(stab_err), 64'd0);
    chk("final_overlap", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
